// File: rtl/mc_delay_ctrl.sv
// Delay-line code controller: sets a single code or sweeps a code range one LSB
// at a time, holding each code for a programmable number of settle cycles.
module mc_delay_ctrl #(
  parameter int unsigned           DelayWidth = 4,
  parameter int unsigned           DwellWidth = 8,
  parameter logic [DelayWidth-1:0] ResetCode  = '0
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  cfg_valid_i,
  output logic                  cfg_ready_o,
  input  logic                  cfg_mode_i,
  input  logic [DelayWidth-1:0] cfg_code_i,
  input  logic [DelayWidth-1:0] cfg_end_i,
  input  logic [DwellWidth-1:0] cfg_dwell_i,
  input  logic                  abort_i,
  output logic [DelayWidth-1:0] delay_o,
  output logic                  busy_o,
  output logic                  sample_o,
  output logic                  done_o
);

  typedef enum logic {
    IDLE   = 1'b0,
    SETTLE = 1'b1
  } state_e;

  state_e                state_q;
  logic [DelayWidth-1:0] delay_q;
  logic [DelayWidth-1:0] end_q;
  logic [DwellWidth-1:0] dwell_q;
  logic [DwellWidth-1:0] cnt_q;
  logic                  mode_q;
  logic                  dir_up_q;
  logic                  terminal;
  logic                  at_end;

  assign terminal    = (state_q == SETTLE) && (cnt_q == '0);
  assign at_end      = (delay_q == end_q);
  assign cfg_ready_o = (state_q == IDLE);
  assign busy_o      = (state_q == SETTLE);
  assign delay_o     = delay_q;

  // An abort in the terminal cycle wins over the pulses, so they are gated
  // combinationally rather than registered one cycle late.
  assign sample_o = terminal && mode_q && !abort_i;
  assign done_o   = terminal && at_end && !abort_i;

  // NOTE: all state uses non-blocking assignments so every register samples
  // the pre-edge values, independent of statement order inside this block.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= IDLE;
      delay_q  <= ResetCode;
      end_q    <= '0;
      dwell_q  <= '0;
      cnt_q    <= '0;
      mode_q   <= 1'b0;
      dir_up_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (cfg_valid_i) begin
            delay_q  <= cfg_code_i;
            mode_q   <= cfg_mode_i;
            end_q    <= cfg_mode_i ? cfg_end_i : cfg_code_i;
            dir_up_q <= cfg_mode_i ? (cfg_end_i >= cfg_code_i) : 1'b1;
            dwell_q  <= cfg_dwell_i;
            cnt_q    <= cfg_dwell_i;
            state_q  <= SETTLE;
          end
        end
        SETTLE: begin
          if (abort_i) begin
            state_q <= IDLE;
          end else if (cnt_q != '0) begin
            cnt_q <= cnt_q - DwellWidth'(1);
          end else if (at_end) begin
            state_q <= IDLE;
          end else begin
            // Direction is fixed at accept, so the sweep lands on end and never wraps.
            delay_q <= dir_up_q ? delay_q + DelayWidth'(1) : delay_q - DelayWidth'(1);
            cnt_q   <= dwell_q;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/mc_delay_ctrl.md
MC_DELAY_CTRL -- requirements
Module: mc_delay_ctrl

Interface
REQ-001 SHALL have parameter DelayWidth, default 4, width of the delay-line select code.
REQ-002 SHALL have parameter DwellWidth, default 8, width of the per-step dwell counter.
REQ-003 SHALL have parameter ResetCode, default 0, the delay code driven out of reset.
REQ-004 SHALL have port clk_i  input  1  the single clock for all state.
REQ-005 SHALL have port rst_i  input  1  asynchronous, active-high reset.
REQ-006 SHALL have port cfg_valid_i  input  1  configuration request valid.
REQ-007 SHALL have port cfg_ready_o  output  1  request accepted when high with cfg_valid_i.
REQ-008 SHALL have port cfg_mode_i  input  1  0 = set single code, 1 = sweep.
REQ-009 SHALL have port cfg_code_i  input  DelayWidth  target code (set) or start code (sweep).
REQ-010 SHALL have port cfg_end_i  input  DelayWidth  sweep end code; ignored in set mode.
REQ-011 SHALL have port cfg_dwell_i  input  DwellWidth  extra settle cycles per code.
REQ-012 SHALL have port abort_i  input  1  terminate the current operation.
REQ-013 SHALL have port delay_o  output  DelayWidth  registered code driving the delay line select.
REQ-014 SHALL have port busy_o  output  1  high whenever not in IDLE.
REQ-015 SHALL have port sample_o  output  1  single-cycle pulse, sweep code settled.
REQ-016 SHALL have port done_o  output  1  single-cycle pulse, operation completed normally.

Function
REQ-017 SHALL implement FSM states IDLE and SETTLE; cfg_ready_o = (state == IDLE); busy_o = (state == SETTLE).
REQ-018 SHALL accept a request on a cycle with cfg_valid_i && cfg_ready_o: delay_o <= cfg_code_i; latch mode, end (set mode: end = cfg_code_i), dwell; cnt <= cfg_dwell_i; next state SETTLE.
REQ-019 SHALL latch direction at accept: up if cfg_end_i >= cfg_code_i, else down; sweep always terminates at end, never wraps.
REQ-020 SHALL decrement cnt once per SETTLE cycle while cnt != 0.
REQ-021 SHALL, in SETTLE with cnt == 0 (the terminal cycle): assert sample_o combinationally if mode = sweep; if delay_o == end, assert done_o and go to IDLE next cycle; else step delay_o by +1/-1 per direction, reload cnt <= dwell, stay in SETTLE.
REQ-022 SHALL keep the accept-to-first-terminal-cycle latency at exactly dwell+1 cycles (dwell 0: terminal cycle is the first SETTLE cycle).
REQ-023 SHALL change delay_o only at accept or by exactly one LSB per step; delay_o holds otherwise, including in IDLE.
REQ-024 SHALL, on abort_i high in SETTLE, go to IDLE next cycle with delay_o unchanged and suppress sample_o and done_o that cycle, even in a terminal cycle.
REQ-025 SHALL ignore abort_i in IDLE; SHALL ignore cfg_valid_i while in SETTLE (no queueing).
REQ-026 SHALL allow a new request to be accepted on the first IDLE cycle after done_o or abort.
REQ-027 SHALL treat a sweep with start == end as one terminal cycle: sample_o and done_o in the same cycle.

Reset
REQ-028 SHALL, while rst_i is high, asynchronously force state IDLE, delay_o = ResetCode, cnt = 0, latched registers = 0; sample_o, done_o, and busy_o read 0.
REQ-029 SHALL, on reset mid-sweep, discard the operation with no done_o; after release, cfg_ready_o = 1 on the next clock edge and delay_o = ResetCode.

Verification
REQ-030 Set mode, code 9, dwell 3 -> delay_o = 9 one cycle after accept; done_o pulse 4 cycles after accept; no sample_o; then IDLE.
REQ-031 Sweep 2->5, dwell 1 -> delay_o 2,3,4,5, each held 2 cycles; four sample_o pulses, one per code; done_o coincides with the 4th pulse.
REQ-032 Sweep 12->10, dwell 0 -> delay_o 12,11,10 on consecutive cycles; sample_o high 3 cycles; done_o on the last.
REQ-033 Sweep 0->15, dwell 2, abort_i asserted when delay_o = 6 -> IDLE next cycle, delay_o stays 6, no done_o; new set to 3 is accepted immediately.
REQ-034 Sweep 4->4, dwell 0 -> sample_o and done_o in the same single cycle.
REQ-035 Reset asserted mid-sweep at delay_o = 7 -> delay_o = 0 immediately, busy_o = 0, no done_o; cfg_ready_o = 1 after release.
